fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips16_pkg.sv | 26 ++
 rtl/fetch_pc.sv | 47 ++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// ============================================================================
// mips16_pkg : shared widths, encodings and FSM state type for the MIPS16 core
// Revision   : 1.0
// ============================================================================
`default_nettype none

package mips16_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FIELD_W = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR       = 16'h0000;
  localparam logic [FIELD_W-1:0] HALT_OP_DEFAULT = 4'hF;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'h0001;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc.sv
// ============================================================================
// fetch_pc : program counter register with next-PC select (reset/redirect/advance)
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pc
  import mips16_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] target,
  input  logic               advance,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] pc_plus1
);

  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] pc_d;

  // Natural 16-bit wrap: 16'hFFFF + 1 becomes 16'h0000
  assign pc_plus1 = pc_q + 16'h0001;
  assign pc       = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = target;
    end else if (advance) begin
      pc_d = pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : IF stage with IF/ID register and RUN/HALT control
//               Optional perf counters enabled by macro FETCH_PERF_CNT_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import mips16_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [FIELD_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_target,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] id_instr,
  output logic [INSTR_W-1:0] id_pc_plus1,
  output logic               id_valid,
  output logic [FIELD_W-1:0] id_opcode,
  output logic [FIELD_W-1:0] id_rs,
  output logic [FIELD_W-1:0] id_rt,
  output logic [FIELD_W-1:0] id_imm4,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_bubble_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [INSTR_W-1:0] id_pc_plus1_q, id_pc_plus1_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] pc_plus1;
  logic               advance;

  // Redirect outranks stall, and stall outranks HALT
  assign advance = !branch_taken && !stall && (state_q == ST_RUN);

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk      (clk),
    .rst      (rst),
    .redirect (branch_taken),
    .target   (branch_target),
    .advance  (advance),
    .pc       (pc),
    .pc_plus1 (pc_plus1)
  );

  always_comb begin
    state_d       = state_q;
    id_instr_d    = id_instr_q;
    id_pc_plus1_d = id_pc_plus1_q;
    id_valid_d    = id_valid_q;
    if (branch_taken) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else if (advance) begin
      id_instr_d    = imem_data;
      id_pc_plus1_d = pc_plus1;
      id_valid_d    = 1'b1;
      if (imem_data[15:12] == HALT_OP) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      id_instr_q    <= NOP_INSTR;
      id_pc_plus1_q <= 16'h0000;
      id_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus1_q <= id_pc_plus1_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign imem_addr   = pc;
  assign id_instr    = id_instr_q;
  assign id_pc_plus1 = id_pc_plus1_q;
  assign id_valid    = id_valid_q;
  assign id_opcode   = id_instr_q[15:12];
  assign id_rs       = id_instr_q[11:8];
  assign id_rt       = id_instr_q[7:4];
  assign id_imm4     = id_instr_q[3:0];
  assign halted      = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [15:0] perf_bubble_cnt_q, perf_bubble_cnt_d;

  always_comb begin
    perf_fetch_cnt_d  = perf_fetch_cnt_q;
    perf_bubble_cnt_d = perf_bubble_cnt_q;
    if (advance) begin
      perf_fetch_cnt_d = sat_inc16(perf_fetch_cnt_q);
    end
    if (stall || branch_taken) begin
      perf_bubble_cnt_d = sat_inc16(perf_bubble_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt_q  <= 16'h0000;
      perf_bubble_cnt_q <= 16'h0000;
    end else begin
      perf_fetch_cnt_q  <= perf_fetch_cnt_d;
      perf_bubble_cnt_q <= perf_bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_cnt_q;
  assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : self-checking bench for fetch_stage (vector table + model)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus1;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic [3:0]  id_imm4;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_bubble_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mem [64];
  logic        use_mem = 1'b0;

  assign imem_data = use_mem ? mem[imem_addr[5:0]] : imem_addr + 16'h1000;

  fetch_stage #(
    .RESET_PC (16'h0000),
    .HALT_OP  (4'hF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .id_instr      (id_instr),
    .id_pc_plus1   (id_pc_plus1),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_imm4       (id_imm4),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state stepped by the priority rules
  logic [15:0] m_pc, m_instr, m_pp1, m_fetch, m_bubble;
  logic        m_valid, m_halted;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return use_mem ? mem[a[5:0]] : a + 16'h1000;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic b, input logic [15:0] t);
    logic [15:0] w;
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_fetch = 16'h0000; m_bubble = 16'h0000;
    end else begin
      if (b || s) m_bubble = (m_bubble == 16'hFFFF) ? m_bubble : m_bubble + 1;
      if (b) begin
        m_pc = t; m_instr = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
      end else if (!s && !m_halted) begin
        w        = mem_word(m_pc);
        m_instr  = w;
        m_pp1    = m_pc + 1;
        m_valid  = 1'b1;
        m_pc     = m_pc + 1;
        m_fetch  = (m_fetch == 16'hFFFF) ? m_fetch : m_fetch + 1;
        m_halted = (w[15:12] == 4'hF);
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    model_step(r, s, b, t);
    @(posedge clk);
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("id_instr", id_instr, m_instr);
    chk("id_valid", {15'd0, id_valid}, {15'd0, m_valid});
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    if (m_valid) chk("id_pc_plus1", id_pc_plus1, m_pp1);
    chk("id_fields", {id_opcode, id_rs, id_rt, id_imm4}, m_instr);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    chk("perf_bubble_cnt", perf_bubble_cnt, m_bubble);
`endif
  endtask

  typedef struct {
    logic        r, s, b;
    logic [15:0] tgt;
    logic [15:0] e_pc, e_instr, e_pp1;
    logic        e_valid;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Directed table: imem returns addr+16'h1000
    tbl[0]  = '{1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
    tbl[1]  = '{0, 0, 0, 16'h0000, 16'h0001, 16'h1000, 16'h0001, 1};
    tbl[2]  = '{0, 0, 0, 16'h0000, 16'h0002, 16'h1001, 16'h0002, 1};
    tbl[3]  = '{0, 0, 0, 16'h0000, 16'h0003, 16'h1002, 16'h0003, 1};
    tbl[4]  = '{0, 0, 0, 16'h0000, 16'h0004, 16'h1003, 16'h0004, 1};
    tbl[5]  = '{0, 0, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1};
    tbl[6]  = '{0, 1, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1};
    tbl[7]  = '{0, 1, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1};
    tbl[8]  = '{0, 1, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1};
    tbl[9]  = '{0, 0, 0, 16'h0000, 16'h0006, 16'h1005, 16'h0006, 1};
    tbl[10] = '{0, 1, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0006, 0};
    tbl[11] = '{0, 0, 0, 16'h0000, 16'h0041, 16'h1040, 16'h0041, 1};
    tbl[12] = '{0, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0041, 0};
    tbl[13] = '{0, 0, 0, 16'h0000, 16'h0000, 16'h0FFF, 16'h0000, 1};
    tbl[14] = '{1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].tgt);
      chk("tbl_pc", imem_addr, tbl[i].e_pc);
      chk("tbl_instr", id_instr, tbl[i].e_instr);
      if (tbl[i].e_valid) chk("tbl_pp1", id_pc_plus1, tbl[i].e_pp1);
      chk("tbl_valid", {15'd0, id_valid}, {15'd0, tbl[i].e_valid});
    end

`ifdef FETCH_PERF_CNT_EN
    // 4 advances, 2 stalls, 1 redirect
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 16'h0020);
    chk("perf_fetch_4", perf_fetch_cnt, 16'd4);
    chk("perf_bubble_3", perf_bubble_cnt, 16'd3);
    tick(1, 0, 0, 0);
    chk("perf_fetch_rst", perf_fetch_cnt, 16'd0);
    chk("perf_bubble_rst", perf_bubble_cnt, 16'd0);
`endif

    // Halt sequence: halt opcode at address 3
    use_mem = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = {4'h1, 12'(i)};
    mem[3] = 16'hF123;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("pre_halt_pc", imem_addr, 16'h0003);
    tick(0, 1, 0, 0);
    chk("stall_blocks_halt", {15'd0, halted}, 16'd0);
    tick(0, 0, 0, 0);
    chk("halted_set", {15'd0, halted}, 16'd1);
    chk("halt_instr", id_instr, 16'hF123);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);
    chk("halt_pc_frozen", imem_addr, 16'h0004);
    chk("halt_valid", {15'd0, id_valid}, 16'd1);
    tick(0, 0, 1, 16'h0010);
    chk("halt_exit", {15'd0, halted}, 16'd0);
    chk("halt_exit_pc", imem_addr, 16'h0010);

    // Reset while halted
    mem[16] = 16'hF000;
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("rst_in_halt", {15'd0, halted}, 16'd0);
    chk("rst_in_halt_pc", imem_addr, 16'h0000);

    // Randomized run against the model
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 3000; n++) begin
      int unsigned p;
      p = $urandom_range(0, 99);
      tick(p < 1, $urandom_range(0, 3) == 0, (p >= 1 && p < 8), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
